// File: rtl/fetch_unit.sv
// Program counter, instruction fetch and bootstrap loader for the 8-bit core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the program (CHK/ERR states).
module fetch_unit #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               clk_valid,
    input  logic               boot_en,
    input  logic               boot_valid,
    input  logic [7:0]         boot_data,
    output logic               boot_ready,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_next,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_we,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic               bootstrapping,
    output logic               boot_err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, RUN, ERR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t LOAD_DONE = CHK;
`else
    localparam state_t LOAD_DONE = RUN;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic                accept;
    logic                run;
    logic [ADDR_W-1:0]   len_cnt;

    assign accept  = boot_valid & boot_ready;
    assign len_cnt = {cnt_q[ADDR_W-1:8], boot_data};

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       err;

    // Running XOR of every accepted byte ahead of the checksum byte itself.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chk_q <= '0;
        end else if (clk_valid && accept && state_q != CHK) begin
            chk_q <= chk_q ^ boot_data;
        end
    end
    assign boot_err = err;
`else
    assign boot_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else if (clk_valid) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = boot_en ? LEN_HI : RUN;
            LEN_HI:  if (accept) state_d = LEN_LO;
            LEN_LO:  if (accept) state_d = (len_cnt == '0) ? LOAD_DONE : DATA_HI;
            DATA_HI: if (accept) state_d = DATA_LO;
            DATA_LO: if (accept) state_d = (cnt_q == ADDR_W'(1)) ? LOAD_DONE : DATA_HI;
`ifdef BOOT_CHECKSUM_EN
            CHK:     if (accept) state_d = (boot_data == chk_q) ? RUN : ERR;
`endif
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        boot_ready    = 1'b0;
        bootstrapping = 1'b0;
        run           = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        err           = 1'b0;
`endif
        case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: begin
                boot_ready    = 1'b1;
                bootstrapping = 1'b1;
            end
`ifdef BOOT_CHECKSUM_EN
            ERR: begin
                bootstrapping = 1'b1;
                err           = 1'b1;
            end
`endif
            RUN:     run = 1'b1;
            default: run = 1'b0;
        endcase
    end

    // The final word's write lands on the first RUN cycle; PC and fetch hold
    // for that one cycle so the fetch at pc = 0 reads the completed image.
    always_comb begin
        pc_d      = pc_q;
        waddr_d   = waddr_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        if (!run) begin
            pc_d = '0;
        end else if (!we_q) begin
            if (pc_load)     pc_d = pc_next;
            else if (pc_inc) pc_d = pc_q + 1'b1;
        end
        if (accept) begin
            case (state_q)
                LEN_HI:  cnt_d = ADDR_W'({boot_data[3:0], 8'h00});
                LEN_LO:  cnt_d = len_cnt;
                DATA_HI: hi_d  = boot_data;
                DATA_LO: begin
                    we_d      = 1'b1;
                    wr_addr_d = waddr_q;
                    wdata_d   = INSTR_W'({hi_q, boot_data});
                    waddr_d   = waddr_q + 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q      <= '0;
            waddr_q   <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else if (clk_valid) begin
            pc_q      <= pc_d;
            waddr_q   <= waddr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_wdata  = wdata_q;
    assign imem_addr   = we_q ? wr_addr_q : (run ? pc_q : waddr_q);
    assign instruction = (run && !we_q) ? imem_rdata : '0;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized boot streams and PC traffic against a queue/array model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        clk_valid = 1'b0;
    logic        boot_en = 1'b0;
    logic        boot_valid = 1'b0;
    logic [7:0]  boot_data = '0;
    logic        boot_ready;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_next = '0;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_we;
    logic [15:0] imem_wdata;
    logic [15:0] instruction;
    logic [11:0] pc;
    logic        bootstrapping;
    logic        boot_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [4096];
    bit          mem_init = 1'b0;
    logic [27:0] wq [$];

    fetch_unit dut (
        .clk(clk), .arst_n(arst_n), .clk_valid(clk_valid), .boot_en(boot_en),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_ready(boot_ready),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_next(pc_next),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_we(imem_we),
        .imem_wdata(imem_wdata), .instruction(instruction), .pc(pc),
        .bootstrapping(bootstrapping), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    // External asynchronous-read memory plus a log of writes taken on enabled edges.
    assign imem_rdata = mem[imem_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
            mem[0] = 16'hBEEF;
            mem_init = 1'b1;
        end else if (imem_we) begin
            mem[imem_addr] = imem_wdata;
        end
        if (imem_we && clk_valid && arst_n) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic do_reset(input bit ben);
        @(negedge clk);
        arst_n = 1'b0; clk_valid = 1'b0; boot_valid = 1'b0;
        pc_inc = 1'b0; pc_load = 1'b0; boot_en = ben;
        #1;
        checks++;
        if ({bootstrapping, boot_ready, imem_we, boot_err} !== 4'b0000 || pc !== 12'h000
            || instruction !== 16'h0000) begin
            failures++;
            $display("FAIL reset_values got bs=%b rdy=%b we=%b err=%b pc=%h instr=%h exp all zero",
                     bootstrapping, boot_ready, imem_we, boot_err, pc, instruction);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic step();
        clk_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            checks++;
            if (bootstrapping !== 1'b1 || pc !== 12'h000 || instruction !== 16'h0000) begin
                failures++;
                $display("FAIL loading_outputs got bs=%b pc=%h instr=%h exp bs=1 pc=000 instr=0000",
                         bootstrapping, pc, instruction);
            end
            clk_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            boot_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            boot_data  = boot_valid ? b : 8'($urandom);
            pc_inc     = 1'($urandom_range(0, 1));
            pc_load    = 1'($urandom_range(0, 1));
            pc_next    = 12'($urandom);
            boot_en    = 1'($urandom_range(0, 1));
            done = boot_valid && clk_valid && boot_ready;
            n++;
        end
        if (!done) begin
            failures++;
            $display("FAIL byte_accept_timeout got no acceptance exp byte %h accepted", b);
        end
    endtask

    // Streams the program (plus checksum when built with it) and checks the writes it causes.
    task automatic run_load(input logic [7:0] prog [$], input bit gaps);
        logic [11:0] n;
        logic [7:0]  x;
        logic [27:0] exp_w [$];
        n = {prog[0][3:0], prog[1]};
        x = '0;
        foreach (prog[i]) x ^= prog[i];
        for (int i = 0; i < int'(n); i++)
            exp_w.push_back({12'(i), prog[2 + 2 * i], prog[3 + 2 * i]});
        wq.delete();
        foreach (prog[i]) send_byte(prog[i], gaps);
`ifdef BOOT_CHECKSUM_EN
        send_byte(x, gaps);
`endif
        @(negedge clk);
        boot_valid = 1'b0; clk_valid = 1'b1; pc_inc = 1'b0; pc_load = 1'b0;
        checks++;
        if (bootstrapping !== 1'b0 || pc !== 12'h000 || boot_err !== 1'b0) begin
            failures++;
            $display("FAIL load_release got bs=%b pc=%h err=%b exp bs=0 pc=000 err=0",
                     bootstrapping, pc, boot_err);
        end
`ifndef BOOT_CHECKSUM_EN
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== n - 12'd1) begin
            failures++;
            $display("FAIL last_write_strobe got we=%b addr=%h exp we=1 addr=%h",
                     imem_we, imem_addr, n - 12'd1);
        end
`endif
        @(negedge clk);
        checks++;
        if (instruction !== {prog[2], prog[3]} || imem_we !== 1'b0) begin
            failures++;
            $display("FAIL first_fetch got instr=%h we=%b exp instr=%h we=0",
                     instruction, imem_we, {prog[2], prog[3]});
        end
        checks++;
        if (wq.size() != exp_w.size()) begin
            failures++;
            $display("FAIL write_count got %0d exp %0d", wq.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (wq[i] !== exp_w[i]) begin
                    failures++;
                    $display("FAIL write_%0d got addr/data=%h exp %h", i, wq[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bootstrapping !== 1'b0 || instruction !== 16'h0000) begin
                failures++;
                $display("FAIL idle_hold got bs=%b instr=%h exp bs=0 instr=0000", bootstrapping, instruction);
            end
        end
        step();
        checks++;
        if (instruction !== 16'hBEEF || pc !== 12'h000 || imem_addr !== 12'h000) begin
            failures++;
            $display("FAIL direct_run got instr=%h pc=%h exp instr=beef pc=000", instruction, pc);
        end
        repeat (3) begin
            pc_inc = 1'b1; @(negedge clk);
            pc_inc = 1'b0; @(negedge clk);
        end
        checks++;
        if (pc !== 12'h003 || instruction !== mem[3]) begin
            failures++;
            $display("FAIL pc_inc3 got pc=%h instr=%h exp pc=003 instr=%h", pc, instruction, mem[3]);
        end
    endtask

    task automatic test_boot_basic();
        logic [7:0] prog [$];
        prog = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        do_reset(1'b1);
        step();
        run_load(prog, 1'b0);
        checks++;
        if (mem[1] !== 16'hABCD) begin
            failures++;
            $display("FAIL mem1_contents got %h exp abcd", mem[1]);
        end
    endtask

    task automatic test_pc();
        logic [11:0] exp_pc;
        do_reset(1'b0);
        step();
        pc_load = 1'b1; pc_inc = 1'b1; pc_next = 12'h2A5;
        @(negedge clk);
        pc_load = 1'b0; pc_inc = 1'b0;
        checks++;
        if (pc !== 12'h2A5) begin
            failures++;
            $display("FAIL load_priority got pc=%h exp 2a5", pc);
        end
        pc_load = 1'b1; pc_next = 12'hFFF; @(negedge clk);
        pc_load = 1'b0; pc_inc = 1'b1; @(negedge clk);
        pc_inc = 1'b0;
        checks++;
        if (pc !== 12'h000) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h exp 000", pc);
        end
        exp_pc = 12'h000;
        for (int i = 0; i < 150; i++) begin
            clk_valid = ($urandom_range(0, 3) != 0);
            pc_inc    = 1'($urandom_range(0, 1));
            pc_load   = ($urandom_range(0, 4) == 0);
            pc_next   = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
            if (clk_valid) begin
                if (pc_load)     exp_pc = pc_next;
                else if (pc_inc) exp_pc = 12'((int'(exp_pc) + 1) % 4096);
            end
            @(negedge clk);
            checks++;
            if (pc !== exp_pc || imem_addr !== exp_pc || instruction !== mem[exp_pc]) begin
                failures++;
                $display("FAIL pc_random_%0d got pc=%h addr=%h instr=%h exp pc=%h instr=%h",
                         i, pc, imem_addr, instruction, exp_pc, mem[exp_pc]);
            end
        end
        pc_inc = 1'b0; pc_load = 1'b0; clk_valid = 1'b1;
    endtask

    task automatic test_gapped_loads();
        logic [7:0] prog [$];
        int len;
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 5);
            prog.delete();
            prog.push_back({4'($urandom), 4'h0});
            prog.push_back(8'(len));
            for (int i = 0; i < 2 * len; i++) prog.push_back(8'($urandom));
            do_reset(1'b1);
            step();
            run_load(prog, 1'b1);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] prog [$];
        prog = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        do_reset(1'b1);
        step();
        for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b0);
        @(negedge clk);
        boot_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1) begin
            failures++;
            $display("FAIL midload_write_pending got we=%b exp 1", imem_we);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({bootstrapping, boot_ready, imem_we, boot_err} !== 4'b0000 || pc !== 12'h000
            || instruction !== 16'h0000) begin
            failures++;
            $display("FAIL midload_reset got bs=%b rdy=%b we=%b err=%b pc=%h instr=%h exp all zero",
                     bootstrapping, boot_ready, imem_we, boot_err, pc, instruction);
        end
        do_reset(1'b1);
        step();
        run_load(prog, 1'b0);
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] prog [$];
        prog = '{8'h00, 8'h01, 8'h12, 8'h34};
        do_reset(1'b1);
        step();
        run_load(prog, 1'b0);
        do_reset(1'b1);
        step();
        foreach (prog[i]) send_byte(prog[i], 1'b0);
        send_byte(8'h27, 1'b0);
        repeat (3) begin
            @(negedge clk);
            boot_valid = 1'b0; clk_valid = 1'b1;
            checks++;
            if (boot_err !== 1'b1 || bootstrapping !== 1'b1 || instruction !== 16'h0000
                || boot_ready !== 1'b0) begin
                failures++;
                $display("FAIL checksum_err got err=%b bs=%b instr=%h rdy=%b exp err=1 bs=1 instr=0000 rdy=0",
                         boot_err, bootstrapping, instruction, boot_ready);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot_basic();
        test_pc();
        test_gapped_loads();
        test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
